// File: rtl/tdc_readout_pkg.sv
// Shared constants for the TDC readout buffer: frame geometry and header format.
// Header-per-frame support is selected by TDC_READOUT_FRAME_HEADER_EN.
// No logic here; constants and one helper function only.
package tdc_readout_pkg;

    localparam int DATA_W        = 16;
    localparam int N_TDC         = 4;
    localparam int WORDS_PER_TDC = 2;

`ifdef TDC_READOUT_FRAME_HEADER_EN
    // One header word leads each frame of sequencer data.
    localparam int WORDS_PER_FRAME = N_TDC * WORDS_PER_TDC + 1;
`else
    localparam int WORDS_PER_FRAME = N_TDC * WORDS_PER_TDC;
`endif

    localparam logic [7:0] HEADER_MARKER = 8'hA5;

    // Header word: marker byte in the top half, run number in the bottom half.
    function automatic logic [DATA_W-1:0] make_header(input logic [7:0] run_id);
        return {HEADER_MARKER, run_id};
    endfunction

endpackage

// File: rtl/tdc_buffer_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset.
// Latency: read data appears one cycle after i_re; o_rdata holds when i_re is low.
// No backpressure; the caller guarantees address validity.
module tdc_buffer_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];

    // Write and registered read; kept reset-free so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/tdc_readout_buffer.sv
// Circular capture buffer between the TDC sequencer and the host; optional frame
// headers with TDC_READOUT_FRAME_HEADER_EN. Latency: rd_valid/rd_data 1 cycle after rd_req.
// Backpressure: none to the sequencer; words arriving while full are dropped and flagged.
module tdc_readout_buffer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              write,
    input  logic [DATA_W-1:0] data,
    input  logic              measure_flag,
    input  logic              clear,
    input  logic              rd_req,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [ADDR_W:0]   word_count,
    output logic [ADDR_W:0]   frame_count,
    output logic              empty,
    output logic              full,
    output logic              overflow
);

    import tdc_readout_pkg::*;

    localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(2**ADDR_W);
    localparam logic [ADDR_W:0] C_WPF   = (ADDR_W+1)'(WORDS_PER_FRAME);

    logic              r_write_d;
    logic              r_armed;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_word_count;
    logic [ADDR_W:0]   r_frame_count;
    logic              r_empty;
    logic              r_full;
    logic              r_overflow;
    logic              r_rd_valid;
    logic              r_rd_seen;

    logic              w_cap;
    logic              w_wr_try;
    logic [DATA_W-1:0] w_wr_dat;
    logic              w_do_wr;
    logic              w_do_rd;
    logic [ADDR_W:0]   w_count_nxt;
    logic [DATA_W-1:0] w_ram_q;

    // r_armed blocks the first cycle after reset so a write already high at release is not seen as an edge.
    assign w_cap = r_armed & write & ~r_write_d;

`ifdef TDC_READOUT_FRAME_HEADER_EN
    logic       r_meas_d;
    logic       r_hdr_pend;
    logic [7:0] r_run_id;
    logic       w_meas_edge;
    logic       w_hdr_go;

    assign w_meas_edge = r_armed & measure_flag & ~r_meas_d;
    // Data owns the write port; a pending header waits for the first free cycle.
    assign w_hdr_go    = r_hdr_pend & ~w_cap;
    assign w_wr_try    = w_cap | w_hdr_go;
    assign w_wr_dat    = w_cap ? data : make_header(r_run_id);

    // Header pending flag and run number; a header dropped while full still consumes its run_id.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_meas_d   <= 1'b0;
            r_hdr_pend <= 1'b0;
            r_run_id   <= 8'd0;
        end else begin
            r_meas_d <= measure_flag;
            if (clear) begin
                r_hdr_pend <= 1'b0;
                r_run_id   <= 8'd0;
            end else begin
                r_hdr_pend <= w_meas_edge | (r_hdr_pend & w_cap);
                if (w_hdr_go) begin
                    r_run_id <= r_run_id + 8'd1;
                end
            end
        end
    end
`else
    logic w_unused_meas;
    assign w_unused_meas = measure_flag;
    assign w_wr_try      = w_cap;
    assign w_wr_dat      = data;
`endif

    // Full/empty are the registered state from before this cycle's read, so a full buffer drops a coincident capture.
    assign w_do_wr     = w_wr_try & ~r_full & ~clear;
    assign w_do_rd     = rd_req & ~r_empty & ~clear;
    assign w_count_nxt = r_word_count + {{ADDR_W{1'b0}}, w_do_wr} - {{ADDR_W{1'b0}}, w_do_rd};

    // Edge detect on the sequencer write strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_write_d <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_write_d <= write;
            r_armed   <= 1'b1;
        end
    end

    // Pointers, occupancy, derived flags and read handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_word_count  <= '0;
            r_frame_count <= '0;
            r_empty       <= 1'b1;
            r_full        <= 1'b0;
            r_overflow    <= 1'b0;
            r_rd_valid    <= 1'b0;
            r_rd_seen     <= 1'b0;
        end else if (clear) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_word_count  <= '0;
            r_frame_count <= '0;
            r_empty       <= 1'b1;
            r_full        <= 1'b0;
            r_overflow    <= 1'b0;
            r_rd_valid    <= 1'b0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_rd_seen <= 1'b1;
            end
            if (w_wr_try & r_full) begin
                r_overflow <= 1'b1;
            end
            r_word_count  <= w_count_nxt;
            r_frame_count <= w_count_nxt / C_WPF;
            r_empty       <= (w_count_nxt == '0);
            r_full        <= (w_count_nxt == C_DEPTH);
            r_rd_valid    <= w_do_rd;
        end
    end

    tdc_buffer_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_do_wr),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wr_dat),
        .i_re    (w_do_rd),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_q)
    );

    // The RAM output is undefined until the first read, so present zero until then.
    assign rd_data     = r_rd_seen ? w_ram_q : '0;
    assign rd_valid    = r_rd_valid;
    assign word_count  = r_word_count;
    assign frame_count = r_frame_count;
    assign empty       = r_empty;
    assign full        = r_full;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_tdc_readout_buffer.sv
// Directed bench for tdc_readout_buffer: table-driven run capture/readback plus
// hand-written sequences for hold-high write, full/overflow, clear, simultaneous
// access, pointer wrap and (when TDC_READOUT_FRAME_HEADER_EN is defined) headers.
module tb_tdc_readout_buffer;

`ifdef TDC_READOUT_FRAME_HEADER_EN
    localparam int WPF = 9;
`else
    localparam int WPF = 8;
`endif

    logic        clk;
    logic        reset_n;
    logic        write;
    logic [15:0] data;
    logic        measure_flag;
    logic        clear;
    logic        rd_req;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [8:0]  word_count;
    logic [8:0]  frame_count;
    logic        empty;
    logic        full;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    tdc_readout_buffer #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .write        (write),
        .data         (data),
        .measure_flag (measure_flag),
        .clear        (clear),
        .rd_req       (rd_req),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .word_count   (word_count),
        .frame_count  (frame_count),
        .empty        (empty),
        .full         (full),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dat;
        int          exp_wc;
        logic        exp_empty;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_write(input logic [15:0] d);
        write = 1'b1;
        data  = d;
        cyc();
        write = 1'b0;
        cyc();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        cyc();
    endtask

    vec_t        vecs[8];
    logic [15:0] q[$];
    logic [15:0] exp_d;

    initial begin
        for (int i = 0; i < 8; i++) begin
            vecs[i].dat       = 16'h1001 + 16'(i);
            vecs[i].exp_wc    = i + 1;
            vecs[i].exp_empty = 1'b0;
        end

        reset_n      = 1'b0;
        write        = 1'b1;
        data         = 16'h5555;
        measure_flag = 1'b0;
        clear        = 1'b0;
        rd_req       = 1'b0;
        repeat (3) cyc();

        // Reset state, with write held high across release.
        check("rst_wc", 32'(word_count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        reset_n = 1'b1;
        cyc();
        cyc();
        check("rst_release_no_capture", 32'(word_count), 0);
        write = 1'b0;
        cyc();

        // One sequencer run from the table.
        for (int i = 0; i < 8; i++) begin
            pulse_write(vecs[i].dat);
            check("run_wc", 32'(word_count), 32'(vecs[i].exp_wc));
            check("run_fc", 32'(frame_count), 32'(vecs[i].exp_wc / WPF));
            check("run_empty", 32'(empty), 32'(vecs[i].exp_empty));
        end
        rd_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            check("run_rd_valid", 32'(rd_valid), 1);
            check("run_rd_data", 32'(rd_data), 32'(vecs[i].dat));
        end
        rd_req = 1'b0;
        cyc();
        check("run_rd_valid_drop", 32'(rd_valid), 0);
        check("run_empty_after", 32'(empty), 1);
        check("run_wc_after", 32'(word_count), 0);

        // Read while empty is ignored and rd_data holds.
        rd_req = 1'b1;
        cyc();
        rd_req = 1'b0;
        check("empty_rd_valid", 32'(rd_valid), 0);
        check("empty_rd_hold", 32'(rd_data), 32'h1008);
        cyc();

        // Write held high for 5 cycles captures once.
        write = 1'b1;
        data  = 16'hBEEF;
        repeat (5) cyc();
        write = 1'b0;
        cyc();
        check("hold_wc", 32'(word_count), 1);
        rd_req = 1'b1;
        cyc();
        rd_req = 1'b0;
        check("hold_rd_data", 32'(rd_data), 32'hBEEF);
        cyc();
        check("hold_empty", 32'(empty), 1);

        // Fill, overflow, read while full, clear.
        do_clear();
        for (int i = 0; i < 256; i++) pulse_write(16'(i));
        check("fill_full", 32'(full), 1);
        check("fill_wc", 32'(word_count), 256);
        check("fill_fc", 32'(frame_count), 32'(256 / WPF));
        check("fill_ovf_pre", 32'(overflow), 0);
        pulse_write(16'hDEAD);
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_wc", 32'(word_count), 256);
        write  = 1'b1;
        data   = 16'hAAAA;
        rd_req = 1'b1;
        cyc();
        write  = 1'b0;
        rd_req = 1'b0;
        check("fullrw_wc", 32'(word_count), 255);
        check("fullrw_valid", 32'(rd_valid), 1);
        check("fullrw_data", 32'(rd_data), 0);
        check("fullrw_full", 32'(full), 0);
        check("fullrw_ovf", 32'(overflow), 1);
        cyc();
        clear = 1'b1;
        write = 1'b1;
        data  = 16'h7777;
        cyc();
        clear = 1'b0;
        write = 1'b0;
        cyc();
        check("clr_wc", 32'(word_count), 0);
        check("clr_ovf", 32'(overflow), 0);
        check("clr_empty", 32'(empty), 1);
        check("clr_fc", 32'(frame_count), 0);
        check("clr_rd_valid", 32'(rd_valid), 0);

        // Occupancy 3, then simultaneous capture and read.
        pulse_write(16'hA001);
        pulse_write(16'hA002);
        pulse_write(16'hA003);
        check("sim_wc_pre", 32'(word_count), 3);
        write  = 1'b1;
        data   = 16'hA004;
        rd_req = 1'b1;
        cyc();
        write  = 1'b0;
        check("sim_wc", 32'(word_count), 3);
        check("sim_valid", 32'(rd_valid), 1);
        check("sim_data", 32'(rd_data), 32'hA001);
        for (int i = 2; i <= 4; i++) begin
            cyc();
            check("sim_drain", 32'(rd_data), 32'hA000 + 32'(i));
        end
        rd_req = 1'b0;
        cyc();
        check("sim_empty", 32'(empty), 1);

        // 300-word stream with low occupancy; pointers wrap.
        q.delete();
        for (int i = 0; i < 300; i++) begin
            write  = 1'b1;
            data   = 16'h2000 + 16'(i);
            rd_req = (q.size() >= 4);
            cyc();
            if (rd_req) begin
                exp_d = q.pop_front();
                check("wrap_valid", 32'(rd_valid), 1);
                check("wrap_data", 32'(rd_data), 32'(exp_d));
            end
            q.push_back(16'h2000 + 16'(i));
            write  = 1'b0;
            rd_req = 1'b0;
            cyc();
        end
        check("wrap_wc", 32'(word_count), 32'(q.size()));
        check("wrap_ovf", 32'(overflow), 0);
        rd_req = 1'b1;
        while (q.size() > 0) begin
            cyc();
            exp_d = q.pop_front();
            check("wrap_drain", 32'(rd_data), 32'(exp_d));
        end
        rd_req = 1'b0;
        cyc();
        check("wrap_empty", 32'(empty), 1);

`ifdef TDC_READOUT_FRAME_HEADER_EN
        // Two frames with headers, then a measure edge coincident with a write.
        do_clear();
        q.delete();
        for (int f = 0; f < 2; f++) begin
            measure_flag = 1'b1;
            cyc();
            measure_flag = 1'b0;
            cyc();
            q.push_back(16'hA500 + 16'(f));
            for (int i = 0; i < 8; i++) begin
                pulse_write(16'h3000 + 16'(f * 16 + i));
                q.push_back(16'h3000 + 16'(f * 16 + i));
            end
        end
        check("hdr_wc", 32'(word_count), 18);
        check("hdr_fc", 32'(frame_count), 2);
        measure_flag = 1'b1;
        write        = 1'b1;
        data         = 16'h4001;
        cyc();
        measure_flag = 1'b0;
        write        = 1'b0;
        cyc();
        q.push_back(16'h4001);
        q.push_back(16'hA502);
        check("hdr_coinc_wc", 32'(word_count), 20);
        rd_req = 1'b1;
        while (q.size() > 0) begin
            cyc();
            exp_d = q.pop_front();
            check("hdr_rd", 32'(rd_data), 32'(exp_d));
        end
        rd_req = 1'b0;
        cyc();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
